tusca_uc: RTL and testbench
===========================

# tusca_uc

Control unit for the TUSCA climate controller; it drives the datapath `tusca_fd` through its measure → transmit → wait cycle. It issues one-cycle command pulses (`medir_dht11`, `transmite_medida`, `receber_config`, `zera_delay`) and consumes the datapath's completion and error flags. It also retries failed DHT11 reads, services configuration requests between cycles and exposes sticky fault flags.

## Interface
- `MAX_TENTATIVAS`, default 3: consecutive DHT11 read attempts before a measurement fault is declared (range 1..15).
- `TIMEOUT_CICLOS`, default 200_000_000: watchdog limit in clock cycles, used only when `TUSCA_UC_TIMEOUT_EN` is defined.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `ligar` in 1: run enable (level).
- `pedido_config` in 1: configuration request (level, synchronous).
- `fim_delay`, `pronto_medida`, `erro_medida`, `pronto_config`, `erro_config`, `pronto_transmite_medida` in 1 each: datapath status.
- `medir_dht11`, `transmite_medida`, `receber_config`, `zera_delay` out 1 each: one-cycle command pulses.
- `conta_delay` out 1: level; enables the delay counter.
- `gira` out 1: servo enable.
- `falha_medida`, `falha_config`, `falha_tx` out 1 each: sticky fault flags.
- `db_estado` out 4: current state code.

## Operation
- States and codes: INICIAL=0, MEDE=1, AGUARDA_MEDIDA=2, TRANSMITE=3, AGUARDA_TX=4, PREPARA_ESPERA=5, ESPERA=6, CONFIG=7, AGUARDA_CONFIG=8, FALHA=9. Unused codes return to INICIAL.
- INICIAL:
  - `ligar`=1 → MEDE.
  - Clears the attempt counter and all sticky flags.
- MEDE: pulses `medir_dht11` → AGUARDA_MEDIDA.
- AGUARDA_MEDIDA:
  - `erro_medida` increments the attempt counter. If the count is below `MAX_TENTATIVAS`, → MEDE; otherwise → FALHA.
  - `pronto_medida` → TRANSMITE and clears the counter.
  - Both flags in the same cycle: error wins.
- FALHA: sets `falha_medida`, clears the counter → PREPARA_ESPERA. No transmission happens for that cycle.
- TRANSMITE: pulses `transmite_medida` → AGUARDA_TX.
- AGUARDA_TX:
  - `pronto_transmite_medida` → PREPARA_ESPERA.
  - A successful read clears `falha_medida` on entry to TRANSMITE.
- PREPARA_ESPERA: pulses `zera_delay` → ESPERA.
- ESPERA: `conta_delay`=1. Priority order:
  1. `ligar`=0 → INICIAL.
  2. `pedido_config`=1 → CONFIG.
  3. `fim_delay`=1 → MEDE.
- CONFIG: pulses `receber_config` → AGUARDA_CONFIG.
- AGUARDA_CONFIG:
  - `pronto_config` → PREPARA_ESPERA (delay restarts), clears `falha_config`.
  - `erro_config` → PREPARA_ESPERA, sets `falha_config`.
  - Both in the same cycle: error wins.
- `ligar` is sampled only in INICIAL and ESPERA. A handshake in progress always completes.
- `gira` = 1 in every state except INICIAL.

## Timing
- Outputs are Moore, decoded from the state register.
- Each pulse is high for exactly the one cycle spent in its issuing state.
- Latency:
  - `ligar` rising in INICIAL → `medir_dht11` high 1 cycle later.
  - `pronto_medida` → `transmite_medida` 1 cycle later.
  - `pronto_transmite_medida` → `zera_delay` 1 cycle later, `conta_delay` 2 cycles later.
  - `fim_delay` → `medir_dht11` 1 cycle later.
- Status inputs are ignored in states that do not wait on them.
- Reset (asserted at any time, including mid-handshake):
  - state = INICIAL.
  - All outputs 0, counters 0, `db_estado` = 0.
  - Release is synchronous to the next `clock` edge.
- Attempt counter width is 4 bits and saturates; it cannot wrap.

## Configuration
- `TUSCA_UC_TIMEOUT_EN` defined:
  - A watchdog counts cycles in AGUARDA_MEDIDA, AGUARDA_TX and AGUARDA_CONFIG. It clears on every state change.
  - Reaching `TIMEOUT_CICLOS`:
    - AGUARDA_MEDIDA: treated exactly as `erro_medida`.
    - AGUARDA_TX: sets `falha_tx` → PREPARA_ESPERA.
    - AGUARDA_CONFIG: sets `falha_config` → PREPARA_ESPERA.
  - Counter width is `$clog2(TIMEOUT_CICLOS+1)`.
- Not defined:
  - No watchdog logic is generated; wait states block indefinitely.
  - `falha_tx` is tied to 0.

## Structure
- Package `tusca_pkg` holds:
  - the state encoding constants (codes 0..9), shared with debug displays;
  - default `MAX_TENTATIVAS` and `TIMEOUT_CICLOS`.
- One sub-module, `uc_watchdog`: cycle counter with `clear`, `enable` and a `estouro` output. It is instantiated only under `TUSCA_UC_TIMEOUT_EN`.
- The next-state logic, state register and output decode stay in `tusca_uc`.

## Test plan
- Nominal cycle:
  - Stimulus: `ligar`=1; `pronto_medida` 10 cycles after `medir_dht11`; `pronto_transmite_medida` 20 cycles later; `fim_delay` at 50.
  - Required: `db_estado` sequence 1,2,3,4,5,6,1; each pulse exactly 1 cycle wide.
- Retry:
  - Stimulus: `erro_medida` twice, then `pronto_medida` (`MAX_TENTATIVAS`=3).
  - Required: 3 `medir_dht11` pulses, then `transmite_medida`; `falha_medida`=0.
- Exhausted retries:
  - Stimulus: 3 consecutive `erro_medida`.
  - Required: state 9, `falha_medida`=1, no `transmite_medida`, then `zera_delay`.
- Configuration priority:
  - Stimulus: `pedido_config` and `fim_delay` together in ESPERA.
  - Required: `receber_config` pulse, no `medir_dht11`.
  - Stimulus: `erro_config`.
  - Required: `falha_config`=1, return to ESPERA.
- Reset mid-handshake:
  - Stimulus: `reset`=0 asynchronously while in AGUARDA_TX.
  - Required: all outputs 0 immediately; `db_estado`=0.
- Timeout (macro on, `TIMEOUT_CICLOS`=100):
  - Stimulus: no `pronto_transmite_medida` arrives.
  - Required: after 100 cycles `falha_tx`=1 and `zera_delay` pulses.

Source files
------------

// File: rtl/tusca_pkg.sv
// Shared definitions for the TUSCA control unit: state codes (also used by debug
// displays) and default parameter values.
package tusca_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        MEDE           = 4'd1,
        AGUARDA_MEDIDA = 4'd2,
        TRANSMITE      = 4'd3,
        AGUARDA_TX     = 4'd4,
        PREPARA_ESPERA = 4'd5,
        ESPERA         = 4'd6,
        CONFIG         = 4'd7,
        AGUARDA_CONFIG = 4'd8,
        FALHA          = 4'd9
    } estado_t;

    localparam int unsigned MAX_TENTATIVAS_PADRAO = 3;
    localparam int unsigned TIMEOUT_CICLOS_PADRAO = 200_000_000;

endpackage

// File: rtl/uc_watchdog.sv
// Cycle-count watchdog for tusca_uc handshake waits; built only with TUSCA_UC_TIMEOUT_EN.
// estouro rises in the LIMITE-th consecutive enabled cycle after a clear.
`ifdef TUSCA_UC_TIMEOUT_EN
module uc_watchdog #(
    parameter int unsigned LIMITE = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic estouro
);

    localparam int unsigned W = $clog2(LIMITE + 1);

    logic [W-1:0] contagem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (clear) begin
            contagem <= '0;
        end else if (enable && !estouro) begin
            contagem <= contagem + 1'b1;
        end
    end

    assign estouro = enable && (contagem == W'(LIMITE - 1));

endmodule
`endif

// File: rtl/tusca_uc.sv
// tusca_uc: control FSM sequencing tusca_fd through measure -> transmit -> wait.
// Defining TUSCA_UC_TIMEOUT_EN adds a watchdog on the three handshake wait states.
module tusca_uc
    import tusca_pkg::*;
#(
    parameter int unsigned MAX_TENTATIVAS = MAX_TENTATIVAS_PADRAO
`ifdef TUSCA_UC_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       pedido_config,
    input  logic       fim_delay,
    input  logic       pronto_medida,
    input  logic       erro_medida,
    input  logic       pronto_config,
    input  logic       erro_config,
    input  logic       pronto_transmite_medida,
    output logic       medir_dht11,
    output logic       transmite_medida,
    output logic       receber_config,
    output logic       zera_delay,
    output logic       conta_delay,
    output logic       gira,
    output logic       falha_medida,
    output logic       falha_config,
    output logic       falha_tx,
    output logic [3:0] db_estado
);

    localparam logic [3:0] LIMITE_TENTATIVAS = 4'(MAX_TENTATIVAS);

    estado_t    estado;
    logic [3:0] tentativas;
    logic [3:0] tentativas_inc;
    logic       falha_medida_r;
    logic       falha_config_r;
    logic       estouro;

    assign tentativas_inc = (tentativas == 4'hF) ? 4'hF : tentativas + 4'd1;

`ifdef TUSCA_UC_TIMEOUT_EN
    logic em_espera;
    logic falha_tx_r;

    // Wait states never follow one another, so clearing outside them restarts the count on every state change.
    assign em_espera = (estado == AGUARDA_MEDIDA) || (estado == AGUARDA_TX) ||
                       (estado == AGUARDA_CONFIG);

    uc_watchdog #(
        .LIMITE (TIMEOUT_CICLOS)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (!em_espera),
        .enable  (em_espera),
        .estouro (estouro)
    );

    assign falha_tx = falha_tx_r;
`else
    assign estouro  = 1'b0;
    assign falha_tx = 1'b0;
`endif

    // Handshake: a command is a one-cycle pulse from its issuing state; the datapath answers with a
    // level flag that is honoured only in the matching AGUARDA_* state, error taking priority over done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado         <= INICIAL;
            tentativas     <= 4'd0;
            falha_medida_r <= 1'b0;
            falha_config_r <= 1'b0;
`ifdef TUSCA_UC_TIMEOUT_EN
            falha_tx_r     <= 1'b0;
`endif
        end else begin
            case (estado)
                INICIAL: begin
                    tentativas     <= 4'd0;
                    falha_medida_r <= 1'b0;
                    falha_config_r <= 1'b0;
`ifdef TUSCA_UC_TIMEOUT_EN
                    falha_tx_r     <= 1'b0;
`endif
                    if (ligar) estado <= MEDE;
                end
                MEDE: estado <= AGUARDA_MEDIDA;
                AGUARDA_MEDIDA: begin
                    if (erro_medida || estouro) begin
                        tentativas <= tentativas_inc;
                        if (tentativas_inc < LIMITE_TENTATIVAS) begin
                            estado <= MEDE;
                        end else begin
                            falha_medida_r <= 1'b1;
                            estado         <= FALHA;
                        end
                    end else if (pronto_medida) begin
                        tentativas     <= 4'd0;
                        falha_medida_r <= 1'b0;
                        estado         <= TRANSMITE;
                    end
                end
                FALHA: begin
                    tentativas <= 4'd0;
                    estado     <= PREPARA_ESPERA;
                end
                TRANSMITE: estado <= AGUARDA_TX;
                AGUARDA_TX: begin
                    if (pronto_transmite_medida) begin
                        estado <= PREPARA_ESPERA;
                    end
`ifdef TUSCA_UC_TIMEOUT_EN
                    else if (estouro) begin
                        falha_tx_r <= 1'b1;
                        estado     <= PREPARA_ESPERA;
                    end
`endif
                end
                PREPARA_ESPERA: estado <= ESPERA;
                ESPERA: begin
                    if (!ligar) estado <= INICIAL;
                    else if (pedido_config) estado <= CONFIG;
                    else if (fim_delay) estado <= MEDE;
                end
                CONFIG: estado <= AGUARDA_CONFIG;
                AGUARDA_CONFIG: begin
                    if (erro_config || estouro) begin
                        falha_config_r <= 1'b1;
                        estado         <= PREPARA_ESPERA;
                    end else if (pronto_config) begin
                        falha_config_r <= 1'b0;
                        estado         <= PREPARA_ESPERA;
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end

    assign medir_dht11      = (estado == MEDE);
    assign transmite_medida = (estado == TRANSMITE);
    assign receber_config   = (estado == CONFIG);
    assign zera_delay       = (estado == PREPARA_ESPERA);
    assign conta_delay      = (estado == ESPERA);
    assign gira             = (estado != INICIAL);
    assign falha_medida     = falha_medida_r;
    assign falha_config     = falha_config_r;
    assign db_estado        = estado;

endmodule

// File: tb/tb_tusca_uc.sv
// Bench for tusca_uc: transaction-level model pushes expected command events into a queue,
// a negedge monitor pops and compares every pulse the DUT issues.
module tb_tusca_uc;

    localparam int MAX_T = 3;
    localparam int TO    = 100;
    localparam int W     = 6;

    localparam logic [2:0] EV_MEDIR = 3'd0;
    localparam logic [2:0] EV_TX    = 3'd1;
    localparam logic [2:0] EV_CFG   = 3'd2;
    localparam logic [2:0] EV_ZERA  = 3'd3;
    localparam logic [2:0] EV_FALHA = 3'd4;

    // noise masks over {pedido, fim, pronto_med, erro_med, pronto_cfg, erro_cfg, pronto_tx}
    localparam logic [6:0] NZ_MED    = 7'b1100111;
    localparam logic [6:0] NZ_TX     = 7'b1111110;
    localparam logic [6:0] NZ_CFG    = 7'b1111001;
    localparam logic [6:0] NZ_ESPERA = 7'b0011111;

    logic clock, reset, ligar, pedido_config, fim_delay;
    logic pronto_medida, erro_medida, pronto_config, erro_config, pronto_transmite_medida;
    logic medir_dht11, transmite_medida, receber_config, zera_delay, conta_delay, gira;
    logic falha_medida, falha_config, falha_tx;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic fm, fc, ft;
    logic prev_med, prev_tx, prev_cfg, prev_zera;

    tusca_uc #(
        .MAX_TENTATIVAS (MAX_T)
`ifdef TUSCA_UC_TIMEOUT_EN
        , .TIMEOUT_CICLOS (TO)
`endif
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .ligar                   (ligar),
        .pedido_config           (pedido_config),
        .fim_delay               (fim_delay),
        .pronto_medida           (pronto_medida),
        .erro_medida             (erro_medida),
        .pronto_config           (pronto_config),
        .erro_config             (erro_config),
        .pronto_transmite_medida (pronto_transmite_medida),
        .medir_dht11             (medir_dht11),
        .transmite_medida        (transmite_medida),
        .receber_config          (receber_config),
        .zera_delay              (zera_delay),
        .conta_delay             (conta_delay),
        .gira                    (gira),
        .falha_medida            (falha_medida),
        .falha_config            (falha_config),
        .falha_tx                (falha_tx),
        .db_estado               (db_estado)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic quiet();
        pedido_config           = 1'b0;
        fim_delay               = 1'b0;
        pronto_medida           = 1'b0;
        erro_medida             = 1'b0;
        pronto_config           = 1'b0;
        erro_config             = 1'b0;
        pronto_transmite_medida = 1'b0;
    endtask

    task automatic noise(input logic [6:0] mask);
        {pedido_config, fim_delay, pronto_medida, erro_medida,
         pronto_config, erro_config, pronto_transmite_medida} = 7'($urandom) & mask;
    endtask

    function automatic void push_ev(input logic [2:0] k);
        exp_q.push_back({k, fm, fc, ft});
    endfunction

    task automatic espera_dwell();
        repeat ($urandom_range(0, 8)) begin
            noise(NZ_ESPERA);
            tick();
        end
        quiet();
    endtask

    // ---------------- driver tasks ----------------
    // Called at the negedge where the trigger (ligar or fim_delay) has just been driven.
    task automatic run_measure(input int n_err, input int dwell, input bit tx_timeout);
        int att;
        int n;
        att = (n_err < MAX_T) ? n_err + 1 : MAX_T;
        for (int i = 0; i < att; i++) push_ev(EV_MEDIR);
        if (n_err < MAX_T) begin
            fm = 1'b0;
            push_ev(EV_TX);
            if (tx_timeout) ft = 1'b1;
        end else begin
            fm = 1'b1;
            push_ev(EV_FALHA);
        end
        push_ev(EV_ZERA);

        for (int i = 0; i < att; i++) begin
            tick();
            quiet();
            check("lat_medir", 32'(medir_dht11), 32'd1);
            tick();
            repeat ((dwell < 0) ? int'($urandom_range(0, 6)) : dwell) begin
                noise(NZ_MED);
                tick();
            end
            quiet();
            if (i < n_err) begin
                erro_medida   = 1'b1;
                pronto_medida = 1'($urandom_range(0, 1));
            end else begin
                pronto_medida = 1'b1;
            end
        end
        tick();
        quiet();
        if (n_err < MAX_T) begin
            check("lat_transmite", 32'(transmite_medida), 32'd1);
            tick();
            if (tx_timeout) begin
                n = 0;
                while (zera_delay !== 1'b1 && n < TO + 10) begin
                    tick();
                    n++;
                end
                check("timeout_cycles", 32'(n), 32'(TO));
                check("timeout_falha_tx", 32'(falha_tx), 32'd1);
            end else begin
                repeat ((dwell < 0) ? int'($urandom_range(0, 6)) : dwell) begin
                    noise(NZ_TX);
                    tick();
                end
                quiet();
                pronto_transmite_medida = 1'b1;
                tick();
                quiet();
            end
        end else begin
            check("falha_state", 32'({db_estado, falha_medida, transmite_medida}),
                  32'({4'd9, 1'b1, 1'b0}));
            tick();
        end
        check("lat_zera", 32'(zera_delay), 32'd1);
        tick();
        check("espera_gira", 32'({db_estado, gira}), 32'({4'd6, 1'b1}));
    endtask

    task automatic run_config(input bit err, input bit with_fim);
        push_ev(EV_CFG);
        fc = err;
        push_ev(EV_ZERA);
        quiet();
        pedido_config = 1'b1;
        fim_delay     = with_fim;
        tick();
        quiet();
        check("cfg_priority", 32'({receber_config, medir_dht11}), 32'({1'b1, 1'b0}));
        tick();
        repeat ($urandom_range(0, 6)) begin
            noise(NZ_CFG);
            tick();
        end
        quiet();
        if (err) begin
            erro_config   = 1'b1;
            pronto_config = 1'($urandom_range(0, 1));
        end else begin
            pronto_config = 1'b1;
        end
        tick();
        quiet();
        check("lat_zera_cfg", 32'(zera_delay), 32'd1);
        tick();
        check("cfg_back", 32'({db_estado, falha_config}), 32'({4'd6, err}));
    endtask

    task automatic run_power_cycle();
        quiet();
        ligar         = 1'b0;
        pedido_config = 1'b1;
        fim_delay     = 1'b1;
        tick();
        quiet();
        check("ligar_off", 32'({db_estado, gira, conta_delay}), 32'd0);
        tick();
        check("inicial_clears", 32'({falha_medida, falha_config, falha_tx}), 32'd0);
        fm = 1'b0; fc = 1'b0; ft = 1'b0;
        ligar = 1'b1;
        run_measure(int'($urandom_range(0, MAX_T)), -1, 1'b0);
    endtask

    task automatic run_reset_mid();
        quiet();
        push_ev(EV_MEDIR);
        fm = 1'b0;
        push_ev(EV_TX);
        fim_delay = 1'b1;
        tick();
        quiet();
        tick();
        pronto_medida = 1'b1;
        tick();
        quiet();
        tick();
        repeat (2) tick();
        #2 reset = 1'b0;
        #1;
        check("reset_async_outputs",
              32'({medir_dht11, transmite_medida, receber_config, zera_delay, conta_delay, gira,
                   falha_medida, falha_config, falha_tx, db_estado}), 32'd0);
        check("events_before_reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        fm = 1'b0; fc = 1'b0; ft = 1'b0;
        ligar = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("idle_after_release", 32'(db_estado), 32'd0);
        ligar = 1'b1;
        run_measure(int'($urandom_range(0, MAX_T)), -1, 1'b0);
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic observe(input logic [2:0] k);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d, required no event", k);
        end else begin
            e = exp_q.pop_front();
            check("scoreboard", 32'({k, falha_medida, falha_config, falha_tx}), 32'(e));
        end
    endtask

    always @(negedge clock) begin
        if (reset !== 1'b1) begin
            prev_med  = 1'b0;
            prev_tx   = 1'b0;
            prev_cfg  = 1'b0;
            prev_zera = 1'b0;
        end else begin
            if (prev_zera) check("conta_after_zera", 32'({db_estado, conta_delay}), 32'({4'd6, 1'b1}));
            if (medir_dht11) begin
                check("pulse_width_medir", 32'(prev_med), 32'd0);
                observe(EV_MEDIR);
            end
            if (transmite_medida) begin
                check("pulse_width_tx", 32'(prev_tx), 32'd0);
                observe(EV_TX);
            end
            if (receber_config) begin
                check("pulse_width_cfg", 32'(prev_cfg), 32'd0);
                observe(EV_CFG);
            end
            if (zera_delay) begin
                check("pulse_width_zera", 32'(prev_zera), 32'd0);
                observe(EV_ZERA);
            end
            if (db_estado == 4'd9) observe(EV_FALHA);
            prev_med  = medir_dht11;
            prev_tx   = transmite_medida;
            prev_cfg  = receber_config;
            prev_zera = zera_delay;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int choice;
        quiet();
        ligar = 1'b0;
        fm = 1'b0; fc = 1'b0; ft = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) tick();
        check("reset_outputs",
              32'({medir_dht11, transmite_medida, receber_config, zera_delay, conta_delay, gira,
                   falha_medida, falha_config, falha_tx, db_estado}), 32'd0);
        reset = 1'b1;
        tick();
        check("idle_without_ligar", 32'({db_estado, gira}), 32'd0);

        ligar = 1'b1;
        run_measure(0, 9, 1'b0);
        repeat (49) tick();
        fim_delay = 1'b1;
        run_measure(2, -1, 1'b0);
        espera_dwell();
        fim_delay = 1'b1;
        run_measure(MAX_T, -1, 1'b0);
        espera_dwell();
        run_config(1'b1, 1'b1);
        espera_dwell();
        run_config(1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            espera_dwell();
            choice = int'($urandom_range(0, 9));
            if (choice <= 5) begin
                fim_delay = 1'b1;
                run_measure(int'($urandom_range(0, MAX_T)), -1, 1'b0);
            end else if (choice <= 7) begin
                run_config(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (choice == 8) begin
                run_power_cycle();
            end else begin
                run_reset_mid();
            end
        end

`ifdef TUSCA_UC_TIMEOUT_EN
        espera_dwell();
        fim_delay = 1'b1;
        run_measure(0, -1, 1'b1);
`endif

        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
